// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, fetch-latency-matched sync/blank delay line, registered RGB.
// Optional macro VGA_TEST_PATTERN_EN replaces framebuffer RGB with 8 vertical colour bars.
module vga_timing_gen #(
    parameter int   C_depth         = 8,
    parameter int   C_fetch_latency = 2,
    parameter int   C_h_visible     = 1024,
    parameter int   C_h_fp          = 16,
    parameter int   C_h_sync        = 96,
    parameter int   C_h_bp          = 152,
    parameter int   C_v_visible     = 768,
    parameter int   C_v_fp          = 3,
    parameter int   C_v_sync        = 6,
    parameter int   C_v_bp          = 13,
    parameter logic C_hsync_pol     = 1'b0,
    parameter logic C_vsync_pol     = 1'b0
) (
    input  logic               clk_pixel,
    input  logic               reset,
    output logic [10:0]        beam_x,
    output logic [9:0]         beam_y,
    output logic               beam_active,
    input  logic [C_depth-1:0] in_red,
    input  logic [C_depth-1:0] in_green,
    input  logic [C_depth-1:0] in_blue,
    output logic [C_depth-1:0] vga_red,
    output logic [C_depth-1:0] vga_green,
    output logic [C_depth-1:0] vga_blue,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic               vga_blank,
    output logic               vga_frame_start
);

    localparam int H_TOTAL = C_h_visible + C_h_fp + C_h_sync + C_h_bp;
    localparam int V_TOTAL = C_v_visible + C_v_fp + C_v_sync + C_v_bp;
    localparam int D       = C_fetch_latency + 1;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS      = 11'(C_h_visible);
    localparam logic [10:0] HS_START   = 11'(C_h_visible + C_h_fp);
    localparam logic [10:0] HS_END     = 11'(C_h_visible + C_h_fp + C_h_sync);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS      = 10'(C_v_visible);
    localparam logic [9:0]  VS_START   = 10'(C_v_visible + C_v_fp);
    localparam logic [9:0]  VS_END     = 10'(C_v_visible + C_v_fp + C_v_sync);

    // Delay-line word: [0] hsync active, [1] vsync active, [2] blank, [3] frame start, [6:4] bar index.
`ifdef VGA_TEST_PATTERN_EN
    localparam int PW = 7;
`else
    localparam int PW = 4;
`endif
    localparam logic [PW-1:0] PIPE_RST = {{(PW-3){1'b0}}, 3'b100};

    logic [10:0] beam_x_q, beam_x_d;
    logic [9:0]  beam_y_q, beam_y_d;

    always_comb begin
        beam_x_d = beam_x_q + 11'd1;
        beam_y_d = beam_y_q;
        if (beam_x_q == H_LAST) begin
            beam_x_d = '0;
            if (beam_y_q == V_LAST) begin
                beam_y_d = '0;
            end else begin
                beam_y_d = beam_y_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            beam_x_q <= '0;
            beam_y_q <= '0;
        end else begin
            beam_x_q <= beam_x_d;
            beam_y_q <= beam_y_d;
        end
    end

    assign beam_x      = beam_x_q;
    assign beam_y      = beam_y_q;
    assign beam_active = (beam_x_q < H_VIS) && (beam_y_q < V_VIS);

    logic [PW-1:0] raw_vec;

    // beam_y only moves on the line wrap, so vsync_raw inherently changes with beam_x==0.
    always_comb begin
        raw_vec    = '0;
        raw_vec[0] = (beam_x_q >= HS_START) && (beam_x_q < HS_END);
        raw_vec[1] = (beam_y_q >= VS_START) && (beam_y_q < VS_END);
        raw_vec[2] = !beam_active;
        raw_vec[3] = (beam_x_q == 11'd0) && (beam_y_q == 10'd0);
`ifdef VGA_TEST_PATTERN_EN
        raw_vec[6:4] = beam_x_q[9:7];
`endif
    end

    logic [PW-1:0] pipe_q [1:D];

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= D; k++) begin
                pipe_q[k] <= PIPE_RST;
            end
        end else begin
            pipe_q[1] <= raw_vec;
            for (int k = 2; k <= D; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    // The RGB register sits one stage before the sync outputs, so it qualifies with stage D-1.
    logic       sel_blank;
    logic [2:0] sel_bar;

    generate
        if (C_fetch_latency == 0) begin : g_sel_raw
            assign sel_blank = raw_vec[2];
`ifdef VGA_TEST_PATTERN_EN
            assign sel_bar   = raw_vec[6:4];
`else
            assign sel_bar   = 3'b000;
`endif
        end else begin : g_sel_pipe
            assign sel_blank = pipe_q[C_fetch_latency][2];
`ifdef VGA_TEST_PATTERN_EN
            assign sel_bar   = pipe_q[C_fetch_latency][6:4];
`else
            assign sel_bar   = 3'b000;
`endif
        end
    endgenerate

    logic [3*C_depth-1:0] in_pack;
    logic [3*C_depth-1:0] rgb_pack;

    assign in_pack = {in_red, in_green, in_blue};

`ifdef VGA_TEST_PATTERN_EN
    logic unused_in;
    assign unused_in = ^in_pack;
`else
    logic unused_bar;
    assign unused_bar = ^sel_bar;
`endif

    // Channel gi: 0 = red (bar bit 2), 1 = green (bit 1), 2 = blue (bit 0).
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            logic [C_depth-1:0] ch_src;
            logic [C_depth-1:0] ch_d;
            logic [C_depth-1:0] ch_q;

            always_comb begin
`ifdef VGA_TEST_PATTERN_EN
                ch_src = {C_depth{sel_bar[2-gi]}};
`else
                ch_src = in_pack[(2-gi)*C_depth +: C_depth];
`endif
                ch_d = sel_blank ? '0 : ch_src;
            end

            always_ff @(posedge clk_pixel or posedge reset) begin
                if (reset) begin
                    ch_q <= '0;
                end else begin
                    ch_q <= ch_d;
                end
            end

            assign rgb_pack[(2-gi)*C_depth +: C_depth] = ch_q;
        end
    endgenerate

    assign {vga_red, vga_green, vga_blue} = rgb_pack;

    assign vga_hsync       = pipe_q[D][0] ? C_hsync_pol : ~C_hsync_pol;
    assign vga_vsync       = pipe_q[D][1] ? C_vsync_pol : ~C_vsync_pol;
    assign vga_blank       = pipe_q[D][2];
    assign vga_frame_start = pipe_q[D][3];

endmodule
